// File: rtl/lbdr_input_fifo_if.sv
// Handshake bundle between an upstream link/allocator and the LBDR input FIFO.
// The master drives writes and pops; the slave returns the head flit and status.
interface lbdr_input_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic                  full;
    logic                  empty;
    logic [DATA_WIDTH-1:0] data_out;
    logic [2:0]            flit_id;
    logic [3:0]            dst_addr;
    logic                  overflow;
    logic                  frame_err;

    modport master (
        output valid_in, data_in, rd_en,
        input  full, empty, data_out, flit_id, dst_addr, overflow, frame_err
    );

    modport slave (
        input  valid_in, data_in, rd_en,
        output full, empty, data_out, flit_id, dst_addr, overflow, frame_err
    );
endinterface

// File: rtl/lbdr_input_fifo.sv
// First-word-fall-through input buffer ahead of the LBDR route stage, with
// sticky overflow and write-side packet framing checks.
module lbdr_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst,
    lbdr_input_fifo_if.slave   fifo_bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] ID_HEADER  = 3'b001;
    localparam logic [2:0] ID_PAYLOAD = 3'b010;
    localparam logic [2:0] ID_TAIL    = 3'b100;

    typedef enum logic {S_IDLE, S_IN_PKT} state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  r_overflow;
    logic                  r_frame_err;
    state_t                r_state;
    state_t                w_state_next;
    logic                  w_frame_set;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [2:0]            w_in_id;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    // A pop frees the slot in the same cycle, so a write at full is taken when rd_en is high.
    assign w_wr_ok = fifo_bus.valid_in & (~w_full | fifo_bus.rd_en);
    assign w_rd_ok = fifo_bus.rd_en & ~w_empty;
    assign w_in_id = fifo_bus.data_in[DATA_WIDTH-1 -: 3];

    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_mem[r_wr_ptr] <= fifo_bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (fifo_bus.valid_in && !w_wr_ok) r_overflow  <= 1'b1;
            if (w_frame_set)                   r_frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Framing only tracks accepted flits; erroneous flits are stored regardless.
    always_comb begin
        w_state_next = r_state;
        w_frame_set  = 1'b0;
        if (w_wr_ok) begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_id == ID_HEADER) w_state_next = S_IN_PKT;
                    else                      w_frame_set  = 1'b1;
                end
                S_IN_PKT: begin
                    case (w_in_id)
                        ID_PAYLOAD: w_state_next = S_IN_PKT;
                        ID_TAIL:    w_state_next = S_IDLE;
                        default:    w_frame_set  = 1'b1;
                    endcase
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign fifo_bus.full      = w_full;
    assign fifo_bus.empty     = w_empty;
    assign fifo_bus.data_out  = r_mem[r_rd_ptr];
    assign fifo_bus.flit_id   = r_mem[r_rd_ptr][DATA_WIDTH-1 -: 3];
    assign fifo_bus.dst_addr  = r_mem[r_rd_ptr][3:0];
    assign fifo_bus.overflow  = r_overflow;
    assign fifo_bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_lbdr_input_fifo.sv
// Scoreboard bench for lbdr_input_fifo: a queue-based packet model predicts
// the head flit and status flags, and a negedge monitor compares them.
module tb_lbdr_input_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam logic [2:0] H = 3'b001;
    localparam logic [2:0] P = 3'b010;
    localparam logic [2:0] T = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    lbdr_input_fifo_if #(.DATA_WIDTH(DW)) bus ();

    lbdr_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .fifo_bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a plain queue, flags and packet state as booleans.
    logic [DW-1:0] exp_q[$];
    bit            m_ovf;
    bit            m_ferr;
    bit            m_in_pkt;

    function automatic logic [DW-1:0] mk(input logic [2:0] id, input logic [3:0] dst);
        logic [24:0] mid;
        mid = 25'($urandom);
        return {id, mid, dst};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model absorbs the same transaction after the edge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit r);
        bit wr;
        bit rd;
        logic [2:0] id;
        bus.valid_in = v;
        bus.data_in  = d;
        bus.rd_en    = r;
        wr = v && ((exp_q.size() < DEPTH) || r);
        rd = r && (exp_q.size() > 0);
        id = d[DW-1 -: 3];
        @(posedge clk);
        if (rd) void'(exp_q.pop_front());
        if (wr) begin
            exp_q.push_back(d);
            if (!m_in_pkt) begin
                if (id == H) m_in_pkt = 1'b1;
                else         m_ferr   = 1'b1;
            end else begin
                if (id == T)      m_in_pkt = 1'b0;
                else if (id != P) m_ferr   = 1'b1;
            end
        end
        if (v && !wr) m_ovf = 1'b1;
        #1;
        $display("txn v=%0d d=%08h r=%0d wr=%0d rd=%0d depth=%0d", v, d, r, wr, rd, exp_q.size());
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = mk(H, 4'h5);
        bus.rd_en    = 1'b0;
        @(posedge clk);
        exp_q.delete();
        m_ovf    = 1'b0;
        m_ferr   = 1'b0;
        m_in_pkt = 1'b0;
        #1;
        rst          = 1'b0;
        bus.valid_in = 1'b0;
        $display("txn reset");
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks += 4;
            if (bus.empty !== (exp_q.size() == 0)) begin
                errors++;
                $display("FAIL mon_empty: got %0b expected %0b at %0t", bus.empty, exp_q.size() == 0, $time);
            end
            if (bus.full !== (exp_q.size() == DEPTH)) begin
                errors++;
                $display("FAIL mon_full: got %0b expected %0b at %0t", bus.full, exp_q.size() == DEPTH, $time);
            end
            if (bus.overflow !== m_ovf) begin
                errors++;
                $display("FAIL mon_overflow: got %0b expected %0b at %0t", bus.overflow, m_ovf, $time);
            end
            if (bus.frame_err !== m_ferr) begin
                errors++;
                $display("FAIL mon_frame_err: got %0b expected %0b at %0t", bus.frame_err, m_ferr, $time);
            end
            if (exp_q.size() > 0) begin
                checks += 3;
                if (bus.data_out !== exp_q[0]) begin
                    errors++;
                    $display("FAIL mon_data_out: got %08h expected %08h at %0t", bus.data_out, exp_q[0], $time);
                end
                if (bus.flit_id !== exp_q[0][DW-1 -: 3]) begin
                    errors++;
                    $display("FAIL mon_flit_id: got %0b expected %0b at %0t", bus.flit_id, exp_q[0][DW-1 -: 3], $time);
                end
                if (bus.dst_addr !== exp_q[0][3:0]) begin
                    errors++;
                    $display("FAIL mon_dst_addr: got %0h expected %0h at %0t", bus.dst_addr, exp_q[0][3:0], $time);
                end
            end
        end
    end

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.rd_en    = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_empty", 32'(bus.empty), 32'd1);
        chk("reset_full", 32'(bus.full), 32'd0);
        chk("reset_overflow", 32'(bus.overflow), 32'd0);
        chk("reset_frame_err", 32'(bus.frame_err), 32'd0);

        // Fill and drain one packet.
        step(1, mk(H, 4'hA), 0);
        step(1, mk(P, 4'h1), 0);
        step(1, mk(P, 4'h2), 0);
        step(1, mk(T, 4'h3), 0);
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_head_id", 32'(bus.flit_id), 32'(H));
        chk("fill_head_dst", 32'(bus.dst_addr), 32'hA);
        for (int i = 0; i < 4; i++) step(0, '0, 1);
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // Full boundary: read+write accepted, write alone dropped.
        step(1, mk(H, 4'h6), 0);
        step(1, mk(P, 4'h7), 0);
        step(1, mk(P, 4'h8), 0);
        step(1, mk(T, 4'h9), 0);
        step(1, mk(H, 4'hB), 1);
        chk("rw_full_stays_full", 32'(bus.full), 32'd1);
        chk("rw_full_new_head", 32'(bus.flit_id), 32'(P));
        step(1, mk(P, 4'hC), 0);
        chk("drop_overflow", 32'(bus.overflow), 32'd1);
        chk("drop_keeps_dst", 32'(bus.dst_addr), 32'h7);
        for (int i = 0; i < 4; i++) step(0, '0, 1);

        // Wrap-around with single-flit-pair packets.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1, mk(H, 4'(i)), 0);
            step(1, mk(T, 4'(i + 1)), 1);
            step(0, '0, 1);
        end
        chk("wrap_frame_err", 32'(bus.frame_err), 32'd0);
        chk("wrap_overflow", 32'(bus.overflow), 32'd0);
        chk("wrap_empty", 32'(bus.empty), 32'd1);

        // Framing violations.
        step(1, mk(P, 4'h1), 0);
        chk("orphan_payload", 32'(bus.frame_err), 32'd1);
        do_reset();
        step(1, mk(H, 4'h1), 0);
        step(1, mk(H, 4'h2), 0);
        chk("nested_header", 32'(bus.frame_err), 32'd1);
        do_reset();
        step(1, mk(3'b111, 4'hE), 0);
        chk("invalid_id_err", 32'(bus.frame_err), 32'd1);
        chk("invalid_id_stored", 32'(bus.flit_id), 32'h7);

        // Empty edges and mid-packet reset.
        do_reset();
        step(0, '0, 1);
        chk("read_empty", 32'(bus.empty), 32'd1);
        step(1, mk(H, 4'h4), 1);
        chk("rw_empty_write", 32'(bus.empty), 32'd0);
        step(1, mk(P, 4'h4), 0);
        step(1, mk(P, 4'h4), 0);
        do_reset();
        chk("midreset_empty", 32'(bus.empty), 32'd1);
        step(1, mk(P, 4'h4), 0);
        chk("midreset_idle", 32'(bus.frame_err), 32'd1);

        // Randomised traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [2:0] id;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 3)      id = H;
            else if (sel < 6) id = P;
            else if (sel < 9) id = T;
            else              id = 3'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset();
            else step(bit'($urandom_range(0, 1)), mk(id, 4'($urandom)), bit'($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
